tl_sb_scoreboard: RTL and testbench

Parametrised, mask-aware TileLink-UL scoreboard that passively snoops the A and D channels of one TL link and checks every response against an internal reference memory. It tracks one outstanding request per source ID and checks byte-masked PutPartialData correctly. It reports pass/fail counts and a sticky first-error code. It sits in the testbench beside the DUT link, succeeding the single-transaction monitor, and is written in a synthesizable style so it can also be used as an on-chip checker.

---
 rtl/tl_sb_scoreboard.sv | 224 ++++++++++++++++++++++
 tb/tb_tl_sb_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tl_sb_scoreboard.sv
// rtl/tl_sb_scoreboard.sv - mask-aware TileLink-UL scoreboard with per-source tracking table
// Optional response timeout is built when TL_SB_TIMEOUT_EN is defined.
module tl_sb_scoreboard #(
  parameter int DATA_BYTES = 8,
  parameter int ADDR_BITS = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int SOURCE_BITS = 2,
  parameter logic [DATA_BYTES*8-1:0] INIT_PATTERN = {8'hAA, {(DATA_BYTES*8-8){1'b0}}},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_valid,
  input  logic                      a_ready,
  input  logic [2:0]                a_opcode,
  input  logic [SOURCE_BITS-1:0]    a_source,
  input  logic [ADDR_BITS-1:0]      a_address,
  input  logic [DATA_BYTES-1:0]     a_mask,
  input  logic [DATA_BYTES*8-1:0]   a_data,
  input  logic                      d_valid,
  input  logic                      d_ready,
  input  logic [2:0]                d_opcode,
  input  logic [SOURCE_BITS-1:0]    d_source,
  input  logic [DATA_BYTES*8-1:0]   d_data,
  output logic                      mem_init_done,
  output logic [31:0]               pass_count,
  output logic [31:0]               fail_count,
  output logic [SOURCE_BITS:0]      outstanding,
  output logic [2:0]                error_code,
  output logic                      idle
);
  localparam int W = DATA_BYTES * 8;
  localparam int OFF = $clog2(DATA_BYTES);
  localparam int IDX_BITS = $clog2(MEM_DEPTH);
  localparam int NSRC = 1 << SOURCE_BITS;

  if (DATA_BYTES < 4 || DATA_BYTES > 64 || (1 << OFF) != DATA_BYTES ||
      (1 << IDX_BITS) != MEM_DEPTH || MEM_DEPTH < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("tl_sb_scoreboard: illegal parameter combination");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   init_idx_q, init_idx_d;
  logic                  init_done_q, init_done_d;
  logic [NSRC-1:0]       valid_q, valid_d;
  logic [NSRC-1:0]       is_get_q, is_get_d;
  logic [W-1:0]          snap_q [NSRC];
  logic [W-1:0]          snap_d [NSRC];
  logic [DATA_BYTES-1:0] mask_q [NSRC];
  logic [DATA_BYTES-1:0] mask_d [NSRC];
  logic [31:0]           pass_q, pass_d, fail_q, fail_d;
  logic [2:0]            err_q, err_d;
  logic [W-1:0]          mem_q [MEM_DEPTH];

`ifdef TL_SB_TIMEOUT_EN
  localparam int AGE_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [AGE_BITS-1:0]   age_q [NSRC];
  logic [AGE_BITS-1:0]   age_d [NSRC];
`endif

  logic                  a_fire, d_fire, a_in_range, d_pass, to_any;
  logic [ADDR_BITS-1:0]  a_hi_bits;
  logic [IDX_BITS-1:0]   a_idx;
  logic [2:0]            a_code, d_code;
  logic [DATA_BYTES-1:0] d_bad_bytes;
  logic [31:0]           fail_inc;
  logic                  mem_we;
  logic [IDX_BITS-1:0]   mem_wr_idx;
  logic [W-1:0]          mem_wr_data;
  logic [DATA_BYTES-1:0] mem_wr_be;
  logic [SOURCE_BITS:0]  outstanding_cnt;

  assign a_fire     = a_valid && a_ready;
  assign d_fire     = d_valid && d_ready;
  assign a_hi_bits  = a_address >> (OFF + IDX_BITS);
  assign a_in_range = (a_hi_bits == '0);
  assign a_idx      = a_address[OFF +: IDX_BITS];

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    valid_d     = valid_q;
    is_get_d    = is_get_q;
    snap_d      = snap_q;
    mask_d      = mask_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_wr_idx  = a_idx;
    mem_wr_data = a_data;
    mem_wr_be   = '0;
    a_code      = 3'd0;
    d_code      = 3'd0;
    d_pass      = 1'b0;
    to_any      = 1'b0;
    fail_inc    = '0;
    d_bad_bytes = '0;
`ifdef TL_SB_TIMEOUT_EN
    age_d       = age_q;
`endif

    if (state_q == ST_INIT) begin
      mem_we      = 1'b1;
      mem_wr_idx  = init_idx_q;
      mem_wr_data = INIT_PATTERN | W'(init_idx_q);
      mem_wr_be   = '1;
      init_idx_d  = init_idx_q + 1'b1;
      if (init_idx_q == IDX_BITS'(MEM_DEPTH - 1)) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end

    for (int b = 0; b < DATA_BYTES; b++)
      d_bad_bytes[b] = (d_data[8*b +: 8] != snap_q[d_source][8*b +: 8]);

    if (d_fire) begin
      if (!valid_q[d_source])
        d_code = 3'd2;
      else if (d_opcode != {2'b00, is_get_q[d_source]})
        d_code = 3'd3;
      else if (is_get_q[d_source] && |(d_bad_bytes & mask_q[d_source]))
        d_code = 3'd4;
      else
        d_pass = 1'b1;
      valid_d[d_source] = 1'b0;
    end

`ifdef TL_SB_TIMEOUT_EN
    // A response arriving on the expiry cycle wins over the timeout.
    for (int s = 0; s < NSRC; s++) begin
      if (valid_q[s]) age_d[s] = age_q[s] + 1'b1;
      if (valid_q[s] && age_q[s] == AGE_BITS'(TIMEOUT_CYCLES - 1) &&
          !(d_fire && d_source == SOURCE_BITS'(s))) begin
        valid_d[s] = 1'b0;
        to_any     = 1'b1;
        fail_inc   = fail_inc + 32'd1;
      end
    end
`endif

    // valid_d already reflects same-cycle retirement, so a reused source is legal here.
    if (a_fire) begin
      if (state_q == ST_INIT)
        a_code = 3'd6;
      else if (!a_in_range)
        a_code = 3'd5;
      else if (valid_d[a_source])
        a_code = 3'd1;
      else if (a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == 3'd4) begin
        valid_d[a_source]  = 1'b1;
        is_get_d[a_source] = (a_opcode == 3'd4);
        snap_d[a_source]   = mem_q[a_idx];
        mask_d[a_source]   = a_mask;
`ifdef TL_SB_TIMEOUT_EN
        age_d[a_source]    = '0;
`endif
        if (a_opcode != 3'd4) begin
          mem_we    = 1'b1;
          mem_wr_be = (a_opcode == 3'd0) ? '1 : a_mask;
        end
      end else
        a_code = 3'd3;
    end

    fail_inc = fail_inc + {31'd0, a_code != 3'd0} + {31'd0, d_code != 3'd0};
    if (fail_q > 32'hFFFF_FFFF - fail_inc) fail_d = 32'hFFFF_FFFF;
    else fail_d = fail_q + fail_inc;
    if (d_pass && pass_q != 32'hFFFF_FFFF) pass_d = pass_q + 32'd1;

    if (err_q == 3'd0) begin
      if (a_code != 3'd0) err_d = a_code;
      else if (d_code != 3'd0) err_d = d_code;
      else if (to_any) err_d = 3'd7;
    end

    outstanding_cnt = '0;
    for (int s = 0; s < NSRC; s++)
      outstanding_cnt = outstanding_cnt + (SOURCE_BITS+1)'(valid_q[s]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      valid_q     <= '0;
      is_get_q    <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      err_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      valid_q     <= valid_d;
      is_get_q    <= is_get_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    mask_q <= mask_d;
`ifdef TL_SB_TIMEOUT_EN
    age_q  <= age_d;
`endif
    for (int b = 0; b < DATA_BYTES; b++)
      if (mem_we && mem_wr_be[b]) mem_q[mem_wr_idx][8*b +: 8] <= mem_wr_data[8*b +: 8];
  end

  assign mem_init_done = init_done_q;
  assign pass_count    = pass_q;
  assign fail_count    = fail_q;
  assign outstanding   = outstanding_cnt;
  assign error_code    = err_q;
  assign idle          = init_done_q && (outstanding_cnt == '0);
endmodule

// File: tb/tb_tl_sb_scoreboard.sv
// tb/tb_tl_sb_scoreboard.sv - directed self-checking bench for tl_sb_scoreboard
module tb_tl_sb_scoreboard;
  localparam int DB = 8;
  localparam int AB = 32;
  localparam int MD = 16;
  localparam int SB = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, a_ready = 1'b1;
  logic [2:0]    a_opcode = '0;
  logic [SB-1:0] a_source = '0;
  logic [AB-1:0] a_address = '0;
  logic [DB-1:0] a_mask = '0;
  logic [63:0]   a_data = '0;
  logic          d_valid = 1'b0, d_ready = 1'b1;
  logic [2:0]    d_opcode = '0;
  logic [SB-1:0] d_source = '0;
  logic [63:0]   d_data = '0;
  logic          mem_init_done, idle;
  logic [31:0]   pass_count, fail_count;
  logic [SB:0]   outstanding;
  logic [2:0]    error_code;

  int tests_run = 0;
  int tests_failed = 0;

  tl_sb_scoreboard #(
    .DATA_BYTES(DB), .ADDR_BITS(AB), .MEM_DEPTH(MD), .SOURCE_BITS(SB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .d_data(d_data),
    .mem_init_done(mem_init_done), .pass_count(pass_count), .fail_count(fail_count),
    .outstanding(outstanding), .error_code(error_code), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic [2:0] op, input logic [SB-1:0] src, input logic [AB-1:0] addr,
                       input logic [DB-1:0] mask, input logic [63:0] data);
    a_valid = 1'b1; a_opcode = op; a_source = src; a_address = addr; a_mask = mask; a_data = data;
  endtask

  task automatic set_d(input logic [2:0] op, input logic [SB-1:0] src, input logic [63:0] data);
    d_valid = 1'b1; d_opcode = op; d_source = src; d_data = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    d_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!mem_init_done && n < 200) begin
      step();
      n++;
    end
    check("init_wait", mem_init_done, 1);
  endtask

  initial begin
    // reset state
    step(); step();
    check("rst_done", mem_init_done, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_outst", outstanding, 0);
    check("rst_err", error_code, 0);
    check("rst_idle", idle, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= MD; i++) begin
      step();
      if (i == MD - 1) check("init_early", mem_init_done, 0);
    end
    check("init_done", mem_init_done, 1);
    check("init_idle", idle, 1);

    // reference memory initial contents
    set_a(3'd4, 2'd0, 32'h18, 8'hFF, 64'h0); step();
    check("get18_outst", outstanding, 1);
    check("get18_idle", idle, 0);
    set_d(3'd1, 2'd0, 64'hAA00_0000_0000_0003); step();
    check("get18_pass", pass_count, 1);
    check("get18_err", error_code, 0);
    check("get18_outst0", outstanding, 0);

    // full then partial write
    set_a(3'd0, 2'd0, 32'h20, 8'hFF, 64'h1122_3344_5566_7788); step();
    set_d(3'd0, 2'd0, 64'h0); step();
    set_a(3'd1, 2'd0, 32'h20, 8'h0F, 64'h0000_0000_AABB_CCDD); step();
    set_d(3'd0, 2'd0, 64'h0); step();
    set_a(3'd4, 2'd0, 32'h20, 8'hFF, 64'h0); step();
    set_d(3'd1, 2'd0, 64'h1122_3344_AABB_CCDD); step();
    check("mask_pass", pass_count, 4);
    check("mask_fail", fail_count, 0);

    // unmasked bytes are don't-care on a Get
    set_a(3'd4, 2'd1, 32'h20, 8'h0F, 64'h0); step();
    set_d(3'd1, 2'd1, 64'hDEAD_BEEF_AABB_CCDD); step();
    check("dontcare_pass", pass_count, 5);

    // no handshake, no entry
    a_ready = 1'b0;
    set_a(3'd4, 2'd2, 32'h0, 8'hFF, 64'h0); step();
    a_ready = 1'b1;
    check("noready_outst", outstanding, 0);

    // four outstanding, out-of-order responses
    for (int s = 0; s < 4; s++) begin
      set_a(3'd4, 2'(s), 32'(s * 8), 8'hFF, 64'h0); step();
    end
    check("conc_outst4", outstanding, 4);
    check("conc_idle0", idle, 0);
    set_d(3'd1, 2'd3, 64'hAA00_0000_0000_0003); step();
    set_d(3'd1, 2'd1, 64'hAA00_0000_0000_0001); step();
    set_d(3'd1, 2'd0, 64'hAA00_0000_0000_0000); step();
    set_d(3'd1, 2'd2, 64'hAA00_0000_0000_0002); step();
    check("conc_pass", pass_count, 9);
    check("conc_outst0", outstanding, 0);
    check("conc_idle1", idle, 1);
    check("conc_fail", fail_count, 0);

    // same-cycle retire and reallocate on one source
    set_a(3'd4, 2'd0, 32'h8, 8'hFF, 64'h0); step();
    set_d(3'd1, 2'd0, 64'hAA00_0000_0000_0001);
    set_a(3'd4, 2'd0, 32'h10, 8'hFF, 64'h0); step();
    check("reuse_outst", outstanding, 1);
    check("reuse_err", error_code, 0);
    check("reuse_pass1", pass_count, 10);
    set_d(3'd1, 2'd0, 64'hAA00_0000_0000_0002); step();
    check("reuse_pass2", pass_count, 11);

    // protocol errors
    set_a(3'd4, 2'd1, 32'h0, 8'hFF, 64'h0); step();
    set_a(3'd4, 2'd1, 32'h8, 8'hFF, 64'h0); step();
    check("dup_fail", fail_count, 1);
    check("dup_err", error_code, 1);
    check("dup_outst", outstanding, 1);
    set_d(3'd1, 2'd1, 64'hAA00_0000_0000_0000); step();
    check("dup_orig_pass", pass_count, 12);
    set_d(3'd1, 2'd2, 64'h0); step();
    check("unexp_fail", fail_count, 2);
    check("unexp_err", error_code, 1);
    set_a(3'd4, 2'd2, 32'(MD * 8), 8'hFF, 64'h0); step();
    check("range_fail", fail_count, 3);
    check("range_err", error_code, 1);
    check("range_outst", outstanding, 0);
    set_a(3'd2, 2'd2, 32'h0, 8'hFF, 64'h0); step();
    check("badop_fail", fail_count, 4);
    check("badop_outst", outstanding, 0);

    // reset mid-INIT, then A during INIT
    reset_pulse();
    check("rst2_pass", pass_count, 0);
    check("rst2_fail", fail_count, 0);
    check("rst2_err", error_code, 0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0; step();
    check("rst3_done", mem_init_done, 0);
    rst_n = 1'b1;
    set_a(3'd4, 2'd0, 32'h0, 8'hFF, 64'h0); step();
    check("notready_fail", fail_count, 1);
    check("notready_err", error_code, 6);
    check("notready_outst", outstanding, 0);
    for (int i = 2; i <= MD; i++) begin
      step();
      if (i == MD - 1) check("reinit_early", mem_init_done, 0);
    end
    check("reinit_done", mem_init_done, 1);

    // memory reinitialised by reset; write visibility; data mismatch
    reset_pulse();
    wait_init();
    set_a(3'd4, 2'd3, 32'h20, 8'hFF, 64'h0); step();
    set_d(3'd1, 2'd3, 64'hAA00_0000_0000_0004); step();
    check("reinit_mem_pass", pass_count, 1);
    set_a(3'd0, 2'd2, 32'h30, 8'hFF, 64'hCAFE_F00D_1234_5678); step();
    set_a(3'd4, 2'd1, 32'h30, 8'hFF, 64'h0); step();
    set_d(3'd0, 2'd2, 64'h0); step();
    set_d(3'd1, 2'd1, 64'hCAFE_F00D_1234_5678); step();
    check("visib_pass", pass_count, 3);
    check("visib_fail", fail_count, 0);
    set_a(3'd0, 2'd0, 32'h28, 8'hFF, 64'h0102_0304_0506_0708); step();
    set_d(3'd0, 2'd0, 64'h0); step();
    set_a(3'd4, 2'd0, 32'h28, 8'hF0, 64'h0); step();
    set_d(3'd1, 2'd0, 64'h0102_0305_0506_0708); step();
    check("data_fail", fail_count, 1);
    check("data_err", error_code, 4);
    check("data_outst", outstanding, 0);
    set_a(3'd0, 2'd1, 32'h28, 8'hFF, 64'h0); step();
    set_d(3'd1, 2'd1, 64'h0); step();
    check("opc_fail", fail_count, 2);
    check("opc_err", error_code, 4);
    check("opc_pass", pass_count, 4);

`ifdef TL_SB_TIMEOUT_EN
    reset_pulse();
    wait_init();
    set_a(3'd4, 2'd0, 32'h0, 8'hFF, 64'h0); step();
    for (int i = 1; i < TO; i++) step();
    check("to_before_outst", outstanding, 1);
    check("to_before_fail", fail_count, 0);
    step();
    check("to_fail", fail_count, 1);
    check("to_err", error_code, 7);
    check("to_outst", outstanding, 0);
    set_a(3'd4, 2'd1, 32'h0, 8'hFF, 64'h0); step();
    for (int i = 1; i < TO; i++) step();
    set_d(3'd1, 2'd1, 64'hAA00_0000_0000_0000); step();
    check("to_prio_pass", pass_count, 1);
    check("to_prio_fail", fail_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
